// File: rtl/branch_issue_ctrl.sv
// In-order branch issue controller: FIFO of dispatched branches, one in flight to the BEU,
// holds taken redirects toward fetch. Optional perf counters under `BRANCH_ISSUE_PERF_EN.
module branch_issue_ctrl #(
    parameter int DEPTH = 4,
    parameter int SID_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             enq_valid_i,
    output logic             enq_ready_o,
    input  logic [63:0]      enq_pc_i,
    input  logic [31:0]      enq_inst_i,
    input  logic [SID_W-1:0] enq_sid_i,
    input  logic [63:0]      enq_rs1_i,
    input  logic [63:0]      enq_rs2_i,
    input  logic [3:0]       enq_func_i,
    output logic             beu_flush_o,
    output logic             beu_valid_o,
    output logic [63:0]      beu_pc_o,
    output logic [31:0]      beu_inst_o,
    output logic [SID_W-1:0] beu_sid_o,
    output logic [63:0]      beu_rs1_o,
    output logic [63:0]      beu_rs2_o,
    output logic [3:0]       beu_func_o,
    input  logic             beu_valid_i,
    input  logic             beu_redirect_i,
    input  logic [63:0]      beu_redirect_pc_i,
    input  logic [SID_W-1:0] beu_sid_i,
    output logic             redir_valid_o,
    input  logic             redir_ready_i,
    output logic [63:0]      redir_pc_o,
    output logic [SID_W-1:0] redir_sid_o,
    output logic             sid_err_o,
    output logic             busy_o
`ifdef BRANCH_ISSUE_PERF_EN
    ,
    output logic [31:0]      perf_issue_o,
    output logic [31:0]      perf_redir_o,
    output logic [31:0]      perf_stall_o
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [63:0]      pc;
        logic [31:0]      inst;
        logic [SID_W-1:0] sid;
        logic [63:0]      rs1;
        logic [63:0]      rs2;
        logic [3:0]       func;
    } entry_t;

    typedef enum logic [1:0] {ISSUE = 2'd0, WAIT = 2'd1, REDIRECT = 2'd2} state_t;

    entry_t           mem [DEPTH];
    entry_t           head_e;
    logic [PW-1:0]    head, tail;
    logic [CW-1:0]    count;
    state_t           state, state_nxt;
    logic [SID_W-1:0] inflight_sid;
    logic             push, pop, redir_acc, beu_done;

    assign head_e      = mem[head];
    assign beu_flush_o = flush_i;
    assign enq_ready_o = !rst && !flush_i && (count < CW'(DEPTH)) && (state != REDIRECT);
    assign push        = enq_valid_i && enq_ready_o;
    assign pop         = beu_valid_o;
    assign redir_acc   = (state == REDIRECT) && redir_ready_i && !flush_i;
    assign beu_done    = (state == WAIT) && beu_valid_i;
    assign busy_o      = (count != '0) || (state != ISSUE);

    assign beu_pc_o    = head_e.pc;
    assign beu_inst_o  = head_e.inst;
    assign beu_sid_o   = head_e.sid;
    assign beu_rs1_o   = head_e.rs1;
    assign beu_rs2_o   = head_e.rs2;
    assign beu_func_o  = head_e.func;

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) state <= ISSUE;
        else     state <= state_nxt;
    end

    // FSM: next state; flush overrides everything, including a same-cycle redirect accept
    always_comb begin
        state_nxt = state;
        if (flush_i) begin
            state_nxt = ISSUE;
        end else begin
            case (state)
                ISSUE:    if (count != '0) state_nxt = WAIT;
                WAIT:     if (beu_valid_i) state_nxt = beu_redirect_i ? REDIRECT : ISSUE;
                REDIRECT: if (redir_ready_i) state_nxt = ISSUE;
                default:  state_nxt = ISSUE;
            endcase
        end
    end

    // FSM: outputs
    always_comb begin
        beu_valid_o   = !rst && !flush_i && (state == ISSUE) && (count != '0);
        redir_valid_o = (state == REDIRECT);
    end

    // FIFO storage and pointers; a redirect or flush squashes all younger entries
    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush_i || redir_acc) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                mem[tail] <= '{pc: enq_pc_i, inst: enq_inst_i, sid: enq_sid_i,
                               rs1: enq_rs1_i, rs2: enq_rs2_i, func: enq_func_i};
                tail      <= tail + PW'(1);
            end
            if (pop) head <= head + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_sid <= '0;
            redir_pc_o   <= '0;
            redir_sid_o  <= '0;
            sid_err_o    <= 1'b0;
        end else begin
            if (pop) inflight_sid <= head_e.sid;
            if (beu_done && beu_redirect_i) begin
                redir_pc_o  <= beu_redirect_pc_i;
                redir_sid_o <= beu_sid_i;
            end
            if (beu_done && (beu_sid_i != inflight_sid)) sid_err_o <= 1'b1;
        end
    end

`ifdef BRANCH_ISSUE_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_issue_o <= '0;
            perf_redir_o <= '0;
            perf_stall_o <= '0;
        end else begin
            if (beu_valid_o && perf_issue_o != '1) perf_issue_o <= perf_issue_o + 32'd1;
            if (redir_acc && perf_redir_o != '1) perf_redir_o <= perf_redir_o + 32'd1;
            if (enq_valid_i && !enq_ready_o && perf_stall_o != '1)
                perf_stall_o <= perf_stall_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_issue_ctrl.sv
// Randomized bench for branch_issue_ctrl against a queue-based reference model.
module tb_branch_issue_ctrl;
    localparam int DEPTH = 4;
    localparam int SID_W = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst, flush_i, enq_valid_i, enq_ready_o;
    logic [63:0]      enq_pc_i, enq_rs1_i, enq_rs2_i;
    logic [31:0]      enq_inst_i;
    logic [SID_W-1:0] enq_sid_i;
    logic [3:0]       enq_func_i;
    logic             beu_flush_o, beu_valid_o;
    logic [63:0]      beu_pc_o, beu_rs1_o, beu_rs2_o;
    logic [31:0]      beu_inst_o;
    logic [SID_W-1:0] beu_sid_o;
    logic [3:0]       beu_func_o;
    logic             beu_valid_i, beu_redirect_i;
    logic [63:0]      beu_redirect_pc_i;
    logic [SID_W-1:0] beu_sid_i;
    logic             redir_valid_o, redir_ready_i;
    logic [63:0]      redir_pc_o;
    logic [SID_W-1:0] redir_sid_o;
    logic             sid_err_o, busy_o;
`ifdef BRANCH_ISSUE_PERF_EN
    logic [31:0]      perf_issue_o, perf_redir_o, perf_stall_o;
`endif

    branch_issue_ctrl #(.DEPTH(DEPTH), .SID_W(SID_W)) dut (
        .clk(clk), .rst(rst), .flush_i(flush_i),
        .enq_valid_i(enq_valid_i), .enq_ready_o(enq_ready_o),
        .enq_pc_i(enq_pc_i), .enq_inst_i(enq_inst_i), .enq_sid_i(enq_sid_i),
        .enq_rs1_i(enq_rs1_i), .enq_rs2_i(enq_rs2_i), .enq_func_i(enq_func_i),
        .beu_flush_o(beu_flush_o), .beu_valid_o(beu_valid_o),
        .beu_pc_o(beu_pc_o), .beu_inst_o(beu_inst_o), .beu_sid_o(beu_sid_o),
        .beu_rs1_o(beu_rs1_o), .beu_rs2_o(beu_rs2_o), .beu_func_o(beu_func_o),
        .beu_valid_i(beu_valid_i), .beu_redirect_i(beu_redirect_i),
        .beu_redirect_pc_i(beu_redirect_pc_i), .beu_sid_i(beu_sid_i),
        .redir_valid_o(redir_valid_o), .redir_ready_i(redir_ready_i),
        .redir_pc_o(redir_pc_o), .redir_sid_o(redir_sid_o),
        .sid_err_o(sid_err_o), .busy_o(busy_o)
`ifdef BRANCH_ISSUE_PERF_EN
        , .perf_issue_o(perf_issue_o), .perf_redir_o(perf_redir_o), .perf_stall_o(perf_stall_o)
`endif
    );

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
        logic [3:0]  sid;
        logic [63:0] rs1;
        logic [63:0] rs2;
        logic [3:0]  func;
    } br_t;

    // Reference model: pending branches, one outstanding BEU op, one pending redirect
    br_t         q[$];
    bit          inflight, rpend, err;
    logic [3:0]  isid, rsid;
    logic [63:0] rpc;
    int unsigned m_issue, m_redir, m_stall;

    int n_chk, n_fail;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int unsigned sat_inc(input int unsigned v);
        return (v == 32'hFFFF_FFFF) ? v : v + 1;
    endfunction

    initial begin
        bit exp_ready, exp_issue, acc;
        br_t b;
        int p_beu;

        n_chk = 0; n_fail = 0;
        rst = 1'b1; flush_i = 1'b0; enq_valid_i = 1'b0;
        enq_pc_i = '0; enq_inst_i = '0; enq_sid_i = '0; enq_rs1_i = '0; enq_rs2_i = '0; enq_func_i = '0;
        beu_valid_i = 1'b0; beu_redirect_i = 1'b0; beu_redirect_pc_i = '0; beu_sid_i = '0;
        redir_ready_i = 1'b0;
        inflight = 0; rpend = 0; err = 0; isid = '0; rsid = '0; rpc = '0;
        m_issue = 0; m_redir = 0; m_stall = 0;
        repeat (2) @(posedge clk);

        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            // alternate slow-BEU blocks (fill the FIFO) with fast-BEU blocks
            p_beu = ((cyc / 150) % 2 == 0) ? 70 : 8;
            rst            = ($urandom_range(0, 399) == 0);
            flush_i        = ($urandom_range(0, 39) == 0);
            enq_valid_i    = ($urandom_range(0, 99) < 70);
            enq_pc_i       = {$urandom, $urandom};
            enq_inst_i     = $urandom;
            enq_sid_i      = 4'($urandom_range(0, 15));
            enq_rs1_i      = {$urandom, $urandom};
            enq_rs2_i      = {$urandom, $urandom};
            case ($urandom_range(0, 2))
                0:       enq_func_i = 4'b0100;
                1:       enq_func_i = 4'b0101;
                default: enq_func_i = 4'b0111;
            endcase
            beu_valid_i       = ($urandom_range(0, 99) < p_beu);
            beu_redirect_i    = ($urandom_range(0, 99) < 30);
            beu_redirect_pc_i = {$urandom, $urandom};
            beu_sid_i         = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : isid;
            redir_ready_i     = ($urandom_range(0, 99) < 40);
            #1;

            exp_ready = !rst && !flush_i && (q.size() < DEPTH) && !rpend;
            exp_issue = !rst && !flush_i && !inflight && !rpend && (q.size() > 0);

            chk("enq_ready", 64'(enq_ready_o), 64'(exp_ready));
            chk("beu_valid", 64'(beu_valid_o), 64'(exp_issue));
            chk("beu_flush", 64'(beu_flush_o), 64'(flush_i));
            chk("redir_valid", 64'(redir_valid_o), 64'(rpend));
            chk("sid_err", 64'(sid_err_o), 64'(err));
            chk("busy", 64'(busy_o), 64'((q.size() > 0) || inflight || rpend));
            if (exp_issue) begin
                chk("beu_pc", beu_pc_o, q[0].pc);
                chk("beu_inst", 64'(beu_inst_o), 64'(q[0].inst));
                chk("beu_sid", 64'(beu_sid_o), 64'(q[0].sid));
                chk("beu_rs1", beu_rs1_o, q[0].rs1);
                chk("beu_rs2", beu_rs2_o, q[0].rs2);
                chk("beu_func", 64'(beu_func_o), 64'(q[0].func));
            end
            if (rpend) begin
                chk("redir_pc", redir_pc_o, rpc);
                chk("redir_sid", 64'(redir_sid_o), 64'(rsid));
            end
`ifdef BRANCH_ISSUE_PERF_EN
            chk("perf_issue", 64'(perf_issue_o), 64'(m_issue));
            chk("perf_redir", 64'(perf_redir_o), 64'(m_redir));
            chk("perf_stall", 64'(perf_stall_o), 64'(m_stall));
`endif

            // advance the model to the state after the coming posedge
            if (rst) begin
                q.delete();
                inflight = 0; rpend = 0; err = 0; isid = '0; rsid = '0; rpc = '0;
                m_issue = 0; m_redir = 0; m_stall = 0;
            end else begin
                acc = rpend && redir_ready_i && !flush_i;
                if (exp_issue) m_issue = sat_inc(m_issue);
                if (acc) m_redir = sat_inc(m_redir);
                if (enq_valid_i && !exp_ready) m_stall = sat_inc(m_stall);
                if (inflight && beu_valid_i && beu_sid_i != isid) err = 1;
                if (flush_i) begin
                    q.delete();
                    inflight = 0;
                    rpend = 0;
                end else if (acc) begin
                    q.delete();
                    rpend = 0;
                end else begin
                    if (inflight && beu_valid_i) begin
                        inflight = 0;
                        if (beu_redirect_i) begin
                            rpend = 1;
                            rpc   = beu_redirect_pc_i;
                            rsid  = beu_sid_i;
                        end
                    end
                    if (exp_issue) begin
                        isid = q[0].sid;
                        void'(q.pop_front());
                        inflight = 1;
                    end
                    if (enq_valid_i && exp_ready) begin
                        b.pc = enq_pc_i; b.inst = enq_inst_i; b.sid = enq_sid_i;
                        b.rs1 = enq_rs1_i; b.rs2 = enq_rs2_i; b.func = enq_func_i;
                        q.push_back(b);
                    end
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
